// File: rtl/wb_regfile_stage.sv
// Writeback stage: M->W pipeline register, result select with byte-load
// sign extension, and a 32x32 register file with write-through bypass.
module wb_regfile_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RegWriteM,
  input  logic [1:0]  ResSrcM,
  input  logic        selM,
  input  logic        FlushW,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ReadDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ImmExtM,
  input  logic [4:0]  RdM,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] ResultW,
  output logic [4:0]  RdW,
  output logic        RegWriteW
);

  logic        reg_write_q, reg_write_d;
  logic [1:0]  res_src_q, res_src_d;
  logic        sel_q, sel_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] imm_ext_q, imm_ext_d;
  logic [4:0]  rd_q, rd_d;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [31:0] result_w;
  logic        wb_en;
  logic [31:0] rd1, rd2;

  // A flush only needs to kill the control fields; data fields are don't-care.
  always_comb begin
    reg_write_d  = RegWriteM;
    res_src_d    = ResSrcM;
    sel_d        = selM;
    alu_result_d = ALUResultM;
    read_data_d  = ReadDataM;
    pc_plus4_d   = PCPlus4M;
    imm_ext_d    = ImmExtM;
    rd_d         = RdM;
    if (FlushW) begin
      reg_write_d = 1'b0;
      res_src_d   = 2'b00;
      sel_d       = 1'b0;
      rd_d        = 5'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      reg_write_q  <= 1'b0;
      res_src_q    <= 2'b00;
      sel_q        <= 1'b0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      imm_ext_q    <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      res_src_q    <= res_src_d;
      sel_q        <= sel_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
      imm_ext_q    <= imm_ext_d;
      rd_q         <= rd_d;
    end
  end

  always_comb begin
    result_w = alu_result_q;
    unique case (res_src_q)
      2'b00: result_w = alu_result_q;
      2'b01: result_w = sel_q ? {{24{read_data_q[7]}}, read_data_q[7:0]} : read_data_q;
      2'b10: result_w = pc_plus4_q;
      2'b11: result_w = imm_ext_q;
      default: result_w = alu_result_q;
    endcase
  end

  assign wb_en = reg_write_q && (rd_q != 5'd0);

  // Writes use the pre-edge W contents, so they coexist with a new capture.
  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      regs_d[rd_q] = result_w;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (Rs1D != 5'd0) begin
      rd1 = (wb_en && (rd_q == Rs1D)) ? result_w : regs_q[Rs1D];
    end
  end

  always_comb begin
    rd2 = '0;
    if (Rs2D != 5'd0) begin
      rd2 = (wb_en && (rd_q == Rs2D)) ? result_w : regs_q[Rs2D];
    end
  end

  assign RD1D      = rd1;
  assign RD2D      = rd2;
  assign ResultW   = result_w;
  assign RdW       = rd_q;
  assign RegWriteW = reg_write_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_wb_regfile_stage;

  logic        Clk;
  logic        Rst;
  logic        RegWriteM;
  logic [1:0]  ResSrcM;
  logic        selM;
  logic        FlushW;
  logic [31:0] ALUResultM;
  logic [31:0] ReadDataM;
  logic [31:0] PCPlus4M;
  logic [31:0] ImmExtM;
  logic [4:0]  RdM;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;

  int errors = 0;
  int checks = 0;

  wb_regfile_stage dut (
    .Clk(Clk), .Rst(Rst), .RegWriteM(RegWriteM), .ResSrcM(ResSrcM),
    .selM(selM), .FlushW(FlushW), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .RdM(RdM), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: the W-stage contents as a record plus a plain array.
  typedef struct {
    bit        rw;
    bit [1:0]  src;
    bit        sel;
    bit [31:0] alu, rdata, pc4, imm;
    bit [4:0]  rd;
    bit        data_valid;
  } w_t;

  w_t        m_w;
  bit [31:0] m_rf [32];

  function automatic bit [31:0] modelResult(w_t w);
    case (w.src)
      2'd0:    return w.alu;
      2'd1:    return w.sel ? 32'($signed(w.rdata[7:0])) : w.rdata;
      2'd2:    return w.pc4;
      default: return w.imm;
    endcase
  endfunction

  function automatic bit [31:0] modelRead(bit [4:0] rs);
    if (rs == 0) return 32'd0;
    if (m_w.rw && m_w.rd != 0 && m_w.rd == rs) return modelResult(m_w);
    return m_rf[rs];
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic compareModel();
    checkOutput("RD1D", RD1D, modelRead(Rs1D));
    checkOutput("RD2D", RD2D, modelRead(Rs2D));
    checkOutput("RdW", {27'd0, RdW}, {27'd0, m_w.rd});
    checkOutput("RegWriteW", {31'd0, RegWriteW}, {31'd0, m_w.rw});
    if (m_w.data_valid) checkOutput("ResultW", ResultW, modelResult(m_w));
  endtask

  task automatic applyStimulus(input bit rst, input bit rw, input bit [1:0] src,
                               input bit sel, input bit flush,
                               input bit [31:0] alu, input bit [31:0] rdata,
                               input bit [31:0] pc4, input bit [31:0] imm,
                               input bit [4:0] rd, input bit [4:0] rs1,
                               input bit [4:0] rs2);
    Rst = rst; RegWriteM = rw; ResSrcM = src; selM = sel; FlushW = flush;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; ImmExtM = imm;
    RdM = rd; Rs1D = rs1; Rs2D = rs2;
    #1;
  endtask

  // Advances the model by one edge using the pre-edge state, then the DUT.
  task automatic tick();
    w_t nw;
    if (Rst) begin
      nw = '{default: 0};
      nw.data_valid = 1;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (m_w.rw && m_w.rd != 0) m_rf[m_w.rd] = modelResult(m_w);
      nw.rw = RegWriteM; nw.src = ResSrcM; nw.sel = selM;
      nw.alu = ALUResultM; nw.rdata = ReadDataM; nw.pc4 = PCPlus4M;
      nw.imm = ImmExtM; nw.rd = RdM; nw.data_valid = 1;
      if (FlushW) begin
        nw.rw = 0; nw.src = 0; nw.sel = 0; nw.rd = 0; nw.data_valid = 0;
      end
    end
    @(posedge Clk);
    m_w = nw;
    #1;
  endtask

  task automatic nop(input bit [4:0] rs1, input bit [4:0] rs2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rs1, rs2);
  endtask

  initial begin
    m_w = '{default: 0};
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    tick();

    // Fresh reset reads zero everywhere
    nop(5, 31);
    compareModel();
    checkOutput("lit_reset_rd1", RD1D, 32'd0);
    checkOutput("lit_reset_rd2", RD2D, 32'd0);
    checkOutput("lit_reset_regwrite", {31'd0, RegWriteW}, 32'd0);

    // ALU writeback to x7: bypass first, then from the file
    applyStimulus(0, 1, 2'b00, 0, 0, 32'h1234_5678, 0, 0, 0, 7, 0, 0);
    compareModel();
    tick();
    nop(7, 7);
    compareModel();
    checkOutput("lit_bypass_x7", RD1D, 32'h1234_5678);
    tick();
    nop(7, 0);
    compareModel();
    checkOutput("lit_file_x7", RD1D, 32'h1234_5678);

    // Byte load sign extension, then full-word load
    applyStimulus(0, 1, 2'b01, 1, 0, 0, 32'h0000_0080, 0, 0, 3, 0, 0);
    compareModel();
    tick();
    applyStimulus(0, 1, 2'b01, 0, 0, 0, 32'h0000_0080, 0, 0, 10, 0, 0);
    compareModel();
    checkOutput("lit_lb_result", ResultW, 32'hFFFF_FF80);
    tick();
    nop(3, 10);
    compareModel();
    checkOutput("lit_lw_result", ResultW, 32'h0000_0080);
    checkOutput("lit_file_x3", RD1D, 32'hFFFF_FF80);
    tick();

    // Writes to x0 are discarded
    applyStimulus(0, 1, 2'b00, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    compareModel();
    tick();
    nop(0, 0);
    compareModel();
    checkOutput("lit_x0_bypass", RD1D, 32'd0);
    tick();
    nop(0, 0);
    compareModel();
    checkOutput("lit_x0_file", RD2D, 32'd0);

    // Flush turns the M instruction into a bubble
    applyStimulus(0, 1, 2'b11, 0, 1, 0, 0, 0, 32'h0000_1000, 9, 0, 0);
    compareModel();
    tick();
    nop(9, 9);
    compareModel();
    checkOutput("lit_flush_regwrite", {31'd0, RegWriteW}, 32'd0);
    checkOutput("lit_flush_rdw", {27'd0, RdW}, 32'd0);
    tick();
    nop(9, 0);
    compareModel();
    checkOutput("lit_flush_x9", RD1D, 32'd0);

    // Back-to-back writes to x4, then reset blocks the second write
    applyStimulus(0, 1, 2'b00, 0, 0, 32'd1, 0, 0, 0, 4, 4, 0);
    compareModel();
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 32'd2, 0, 0, 0, 4, 4, 4);
    compareModel();
    checkOutput("lit_x4_first", RD1D, 32'd1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4);
    compareModel();
    checkOutput("lit_x4_second", RD1D, 32'd2);
    tick();
    nop(4, 7);
    compareModel();
    checkOutput("lit_x4_after_rst", RD1D, 32'd0);
    checkOutput("lit_x7_after_rst", RD2D, 32'd0);
    checkOutput("lit_result_after_rst", ResultW, 32'd0);
    for (int a = 0; a < 32; a += 2) begin
      nop(5'(a), 5'(a + 1));
      compareModel();
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit [4:0] rs1, rs2;
      rs1 = ($urandom_range(0, 1) == 0) ? m_w.rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 2) == 0) ? rs1 : 5'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0, $urandom, $urandom, $urandom,
                    $urandom, 5'($urandom_range(0, 31)), rs1, rs2);
      compareModel();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
